button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Turns the five raw, asynchronous, bouncing push-buttons into clean single-cycle press pulses for the opcode generator.
//  - Upstream: board button pins. Downstream: opcode generator (add/sub/mul/square) and operand/select logic (mid).
//  - Per button: 2-flop synchroniser, counter debounce, rising-edge detect.
//  - Guarantees at most one pulse per cycle (one-hot or zero).
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles needed to accept a level change (10 ms @ 100 MHz); legal range >= 2
//  CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk                   in   1  system clock; the only clock
//  rst                   in   1  reset, asynchronous, active-high
//  btn_raw_in            in   5  raw pins: [0]=up/add [1]=left/sub [2]=right/mul [3]=down/square [4]=mid/select
//  b_up_add_out          out  1  one-cycle pulse: accepted press of up
//  b_left_subtract_out   out  1  one-cycle pulse: accepted press of left
//  b_right_multiply_out  out  1  one-cycle pulse: accepted press of right
//  b_down_square_out     out  1  one-cycle pulse: accepted press of down
//  b_mid_select_out      out  1  one-cycle pulse: accepted press of mid
//  btn_level_out         out  5  debounced level per button, same bit order as btn_raw_in
// BEHAVIOUR
//  Reset (async, rst=1):
//  - Sync flops, counters, levels and all pulse outputs go to 0 immediately.
//  - State is held while rst=1. Deassertion takes effect at the next clk edge.
//  - A button held through reset produces a pulse after a full debounce interval; it is treated as a new press.
//  Synchroniser: sync[i] = btn_raw_in[i] delayed 2 clk edges.
//  Debounce, per-button FSM:
//  - STABLE_LO: sync=1 -> go to WAIT_HI, cnt=1.
//  - WAIT_HI: sync=0 -> go to STABLE_LO, cnt=0 (bounce aborts). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> go to STABLE_HI, level=1, cnt=0. Otherwise cnt++.
//  - STABLE_HI / WAIT_LO: same rules with polarity mirrored; level=0 on acceptance.
//  - Net effect: level flips DEBOUNCE_CYCLES edges after sync first differs, provided sync does not glitch back.
//  - Total latency from raw edge to level change: 2+DEBOUNCE_CYCLES cycles.
//  - The counter saturates by construction and never wraps.
//  Edge detect: rise[i]=1 in the first cycle level[i] is 1 only. No pulse is generated on release.
//  Arbitration, output stage:
//  - Registered pulse outputs: pulse[i] is high in the cycle after level[i] rises.
//  - pulse[i] requires rise[i] AND no other level[j] was 1 in the previous cycle.
//  - Simultaneous rises: the lowest index wins. Losers get no pulse, now or later, for that press.
//  - A press made while another button is held is suppressed entirely.
//  - Pulse width is exactly 1 cycle regardless of hold time.
//  - btn_level_out reports raw debounced levels, unaffected by arbitration.
// STRUCTURE
//  - Shared include calc_defines.vh: localparams BTN_ADD=0, BTN_SUB=1, BTN_MUL=2, BTN_SQR=3, BTN_SEL=4, N_BTN=5. The opcode generator uses the same file.
//  - One sub-module, button_debounce (sync + FSM + counter; ports clk, rst, raw_in, level_out), instantiated N_BTN times via generate.
//  - Arbitration and pulse registers live in the top module.
// TESTING  (DEBOUNCE_CYCLES=4, CNT_W=3 in the bench)
//  1. rst=1 with btn_raw_in=5'h1F; hold 10 cycles -> all outputs 0. Release rst -> b_up_add_out pulses once, 7 cycles later.
//  2. Clean press btn[2] at cycle t -> level[2]=1 at t+6, b_right_multiply_out=1 at t+7 only. Hold 50 cycles -> no further pulse. Release -> level falls at +6, no pulse.
//  3. Bounce btn[1] 1,0,1,0 every cycle, then steady 1 -> no pulse during the bounce. Exactly one pulse, 7 cycles after the last 0->1 transition.
//  4. Raise btn[3] and btn[0] on the same edge -> only b_up_add_out pulses. Releasing and re-pressing btn[3] alone afterwards -> b_down_square_out pulses.
//  5. Hold btn[4] (level 1), then press btn[1] -> no b_left_subtract_out pulse. btn_level_out=5'b10010.
//  6. Assert rst asynchronously mid-WAIT_HI (cnt=2) -> level/pulse stay 0 and the FSM restarts. After release, a held button pulses after the full interval.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared button indices, button count, debounce FSM state type and a small
// helper for lowest-index arbitration. The opcode generator imports the same
// package so both sides agree on which bit is which button.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  localparam int BTN_ADD = 0;  // up
  localparam int BTN_SUB = 1;  // left
  localparam int BTN_MUL = 2;  // right
  localparam int BTN_SQR = 3;  // down
  localparam int BTN_SEL = 4;  // mid
  localparam int N_BTN   = 5;

  typedef enum logic [1:0] {
    ST_STABLE_LO,
    ST_WAIT_HI,
    ST_STABLE_HI,
    ST_WAIT_LO
  } deb_state_t;

  // Isolates the lowest set bit: v & -v.
  function automatic logic [N_BTN-1:0] lowest_set(input logic [N_BTN-1:0] v);
    return v & (~v + N_BTN'(1));
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One button: 2-flop synchroniser followed by a counter-based debounce FSM.
// The debounced level only changes after the synchronised input has held the
// new value for DEBOUNCE_CYCLES consecutive clock edges.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   raw_in    in  raw, asynchronous, bouncing button pin
//   level_out out debounced level
// -----------------------------------------------------------------------------
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic             sync;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], raw_in};
    end
  end

  assign sync = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_STABLE_LO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter counts edges on which sync differs from the accepted level;
  // it is cleared on acceptance or on a bounce, so it can never pass CNT_LAST.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_STABLE_LO: begin
        if (sync) begin
          state_next = ST_WAIT_HI;
          cnt_next   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!sync) begin
          state_next = ST_STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_STABLE_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!sync) begin
          state_next = ST_WAIT_LO;
          cnt_next   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (sync) begin
          state_next = ST_STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_STABLE_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  // The accepted level is 1 while high is stable or a release is pending.
  assign level_out = (state_reg == ST_STABLE_HI) || (state_reg == ST_WAIT_LO);

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the five board push-buttons into clean single-cycle press pulses.
// Each button is synchronised and debounced independently; the top then
// edge-detects the debounced levels and arbitrates so that at most one pulse
// fires per cycle.
// Ports:
//   clk                  in  system clock
//   rst                  in  asynchronous active-high reset
//   btn_raw_in[4:0]      in  raw pins: 0=up/add 1=left/sub 2=right/mul
//                            3=down/square 4=mid/select
//   b_*_out              out one-cycle accepted-press pulse per button
//   btn_level_out[4:0]   out debounced levels, not affected by arbitration
// -----------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_in,
  output logic             b_up_add_out,
  output logic             b_left_subtract_out,
  output logic             b_right_multiply_out,
  output logic             b_down_square_out,
  output logic             b_mid_select_out,
  output logic [N_BTN-1:0] btn_level_out
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] level_prev_reg;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pulse_reg, pulse_next;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (btn_raw_in[gi]),
        .level_out (level[gi])
      );
    end
  endgenerate

  assign rise = level & ~level_prev_reg;

  // A rising button has its own previous level at 0, so "no other button was
  // held last cycle" reduces to "no button was held last cycle". A press made
  // while anything is held is therefore dropped for good, and among
  // simultaneous rises the lowest index takes the only pulse.
  always_comb begin
    pulse_next = '0;
    if (level_prev_reg == '0) begin
      pulse_next = lowest_set(rise);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_reg <= '0;
      pulse_reg      <= '0;
    end else begin
      level_prev_reg <= level;
      pulse_reg      <= pulse_next;
    end
  end

  assign b_up_add_out         = pulse_reg[BTN_ADD];
  assign b_left_subtract_out  = pulse_reg[BTN_SUB];
  assign b_right_multiply_out = pulse_reg[BTN_MUL];
  assign b_down_square_out    = pulse_reg[BTN_SQR];
  assign b_mid_select_out     = pulse_reg[BTN_SEL];
  assign btn_level_out        = level;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Reference model: per button, the raw input is delayed two edges, and the
// debounced level flips once the delayed input has disagreed with it on D
// consecutive edges. A pulse is predicted for the lowest newly-risen button
// when no button was held on the previous cycle; predictions are queued and
// a monitor matches them against DUT pulses.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int CW = 3;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = 5'h1F;
  logic          p_up, p_left, p_right, p_down, p_mid;
  logic [NB-1:0] btn_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .btn_raw_in           (btn_raw),
    .b_up_add_out         (p_up),
    .b_left_subtract_out  (p_left),
    .b_right_multiply_out (p_right),
    .b_down_square_out    (p_down),
    .b_mid_select_out     (p_mid),
    .btn_level_out        (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
  } exp_pulse_t;

  exp_pulse_t    exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            edge_cnt = 0;
  int            pcount[NB];
  int            snap[NB];

  // model state
  logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_lvl = '0, m_prev = '0;
  int            m_run[NB];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  task automatic model_clear();
    m_d1   = '0;
    m_d2   = '0;
    m_lvl  = '0;
    m_prev = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    exp_q.delete();
  endtask

  // Asynchronous reset clears the model immediately.
  initial begin
    for (int i = 0; i < NB; i++) begin
      m_run[i]  = 0;
      pcount[i] = 0;
      snap[i]   = 0;
    end
    forever begin
      @(posedge rst);
      model_clear();
    end
  end

  // Model step on every clock edge.
  initial begin
    logic [NB-1:0] old_lvl, old_prev;
    bit            found;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        model_clear();
      end else begin
        old_lvl  = m_lvl;
        old_prev = m_prev;
        found    = 1'b0;
        if (old_prev == '0) begin
          for (int i = 0; i < NB; i++) begin
            if (!found && old_lvl[i]) begin
              exp_q.push_back('{cyc: edge_cnt, idx: i});
              found = 1'b1;
            end
          end
        end
        for (int i = 0; i < NB; i++) begin
          if (m_d2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
              m_lvl[i] = ~m_lvl[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_prev = old_lvl;
        m_d2   = m_d1;
        m_d1   = btn_raw;
      end
    end
  end

  // Monitor: compares levels every cycle and matches pulses to predictions.
  initial begin
    logic [NB-1:0] pulses;
    exp_pulse_t    e;
    int            idx;
    forever begin
      @(negedge clk);
      pulses = {p_mid, p_down, p_right, p_left, p_up};
      check("level", int'(btn_level), int'(m_lvl));
      if (pulses != '0) begin
        check("onehot", $countones(pulses), 1);
        idx = 0;
        for (int i = NB - 1; i >= 0; i--) if (pulses[i]) idx = i;
        pcount[idx]++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'(pulses), 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_idx", idx, e.idx);
          check("pulse_cycle", edge_cnt, e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= edge_cnt) begin
        e = exp_q.pop_front();
        check("missing_pulse", -1, e.idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [NB-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic take_snap();
    #1;
    for (int i = 0; i < NB; i++) snap[i] = pcount[i];
  endtask

  task automatic check_counts(input string name, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
    int e[NB];
    #1;
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < NB; i++) check($sformatf("%s_cnt%0d", name, i), pcount[i] - snap[i], e[i]);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int len;
    logic [NB-1:0] v;
    // 1: all buttons held through reset
    repeat (10) @(negedge clk);
    #1;
    check("rst_level", int'(btn_level), 0);
    check("rst_pulses", int'({p_mid, p_down, p_right, p_left, p_up}), 0);
    take_snap();
    @(negedge clk);
    rst = 1'b0;
    hold(5'h1F, 20);
    hold(5'h00, 20);
    check_counts("t1", 1, 0, 0, 0, 0);
    // 2: clean press of right, long hold, release
    take_snap();
    hold(5'h04, 60);
    hold(5'h00, 20);
    check_counts("t2", 0, 0, 1, 0, 0);
    // 3: bounce on left, then steady
    take_snap();
    hold(5'h02, 1);
    hold(5'h00, 1);
    hold(5'h02, 1);
    hold(5'h00, 1);
    hold(5'h02, 30);
    hold(5'h00, 20);
    check_counts("t3", 0, 1, 0, 0, 0);
    // 4: simultaneous up+down, then down alone
    take_snap();
    hold(5'h09, 30);
    hold(5'h00, 20);
    check_counts("t4a", 1, 0, 0, 0, 0);
    take_snap();
    hold(5'h08, 30);
    hold(5'h00, 20);
    check_counts("t4b", 0, 0, 0, 1, 0);
    // 5: press left while mid is held
    take_snap();
    hold(5'h10, 20);
    hold(5'h12, 30);
    #1;
    check("t5_level", int'(btn_level), 5'b10010);
    check_counts("t5", 0, 0, 0, 0, 1);
    hold(5'h00, 20);
    // 6: reset in the middle of the up-button debounce
    take_snap();
    btn_raw = 5'h01;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_level", int'(btn_level), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(5'h01, 20);
    hold(5'h00, 20);
    check_counts("t6", 1, 0, 0, 0, 0);
    // random stimulus
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 2) == 0) v = 5'(1 << $urandom_range(0, NB - 1));
      else v = 5'($urandom);
      if ($urandom_range(0, 3) == 0) len = $urandom_range(5, 15);
      else len = $urandom_range(1, 4);
      hold(v, len);
      if ($urandom_range(0, 49) == 0) async_reset();
    end
    hold(5'h00, 20);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
